// File: rtl/im_fetch_sequencer.sv
// rtl/im_fetch_sequencer.sv - strided (A) and cyclic (B) item-memory address sequencer
module im_fetch_sequencer #(
  parameter int unsigned NumTotIm     = 1024,
  parameter int unsigned ImAddrWidth  = 32,
  parameter int unsigned CountWidth   = 16,
  parameter int unsigned AddrSelWidth = $clog2(NumTotIm)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    start_i,
  input  logic [CountWidth-1:0]   cfg_num_items_i,
  input  logic [AddrSelWidth-1:0] cfg_a_base_i,
  input  logic [AddrSelWidth-1:0] cfg_a_stride_i,
  input  logic                    cfg_b_en_i,
  input  logic [AddrSelWidth-1:0] cfg_b_base_i,
  input  logic [CountWidth-1:0]   cfg_b_period_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ImAddrWidth-1:0]  lowdim_a_data_o,
  output logic                    im_a_data_valid_o,
  input  logic                    im_a_data_ready_i,
  output logic [ImAddrWidth-1:0]  lowdim_b_data_o,
  output logic                    im_b_data_valid_o,
  input  logic                    im_b_data_ready_i
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [CountWidth-1:0]   num_q, num_d;
  logic [AddrSelWidth-1:0] a_stride_q, a_stride_d;
  logic                    b_en_q, b_en_d;
  logic [AddrSelWidth-1:0] b_base_q, b_base_d;
  logic [CountWidth-1:0]   b_last_q, b_last_d;
  logic [CountWidth-1:0]   a_cnt_q, a_cnt_d;
  logic [CountWidth-1:0]   b_cnt_q, b_cnt_d;
  logic [CountWidth-1:0]   b_phase_q, b_phase_d;
  logic [AddrSelWidth-1:0] a_addr_q, a_addr_d;
  logic [AddrSelWidth-1:0] b_addr_q, b_addr_d;
  logic                    a_valid_q, a_valid_d;
  logic                    b_valid_q, b_valid_d;

  logic                    a_hs, b_hs, a_fin, b_fin;
  logic [CountWidth-1:0]   a_cnt_inc, b_cnt_inc;

  assign a_hs      = a_valid_q && im_a_data_ready_i;
  assign b_hs      = b_valid_q && im_b_data_ready_i;
  assign a_cnt_inc = a_cnt_q + CountWidth'(1);
  assign b_cnt_inc = b_cnt_q + CountWidth'(1);

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    a_stride_d = a_stride_q;
    b_en_d     = b_en_q;
    b_base_d   = b_base_q;
    b_last_d   = b_last_q;
    a_cnt_d    = a_cnt_q;
    b_cnt_d    = b_cnt_q;
    b_phase_d  = b_phase_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    a_valid_d  = a_valid_q;
    b_valid_d  = b_valid_q;
    a_fin      = 1'b0;
    b_fin      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          num_d      = cfg_num_items_i;
          a_stride_d = cfg_a_stride_i;
          b_en_d     = cfg_b_en_i;
          b_base_d   = cfg_b_base_i;
          // A zero period behaves as a period of one: phase always restarts.
          b_last_d   = (cfg_b_period_i == '0) ? '0 : cfg_b_period_i - CountWidth'(1);
          a_cnt_d    = '0;
          b_cnt_d    = '0;
          b_phase_d  = '0;
          if (cfg_num_items_i == '0) begin
            state_d = DONE;
          end else begin
            state_d   = RUN;
            a_valid_d = 1'b1;
            a_addr_d  = cfg_a_base_i;
            b_valid_d = cfg_b_en_i;
            b_addr_d  = cfg_b_en_i ? cfg_b_base_i : '0;
          end
        end
      end
      RUN: begin
        if (a_hs) begin
          a_cnt_d = a_cnt_inc;
          if (a_cnt_inc == num_q) a_valid_d = 1'b0;
          else                    a_addr_d  = a_addr_q + a_stride_q;
        end
        if (b_hs) begin
          b_cnt_d = b_cnt_inc;
          if (b_cnt_inc == num_q) begin
            b_valid_d = 1'b0;
          end else if (b_phase_q == b_last_q) begin
            b_phase_d = '0;
            b_addr_d  = b_base_q;
          end else begin
            b_phase_d = b_phase_q + CountWidth'(1);
            b_addr_d  = b_addr_q + AddrSelWidth'(1);
          end
        end
        a_fin = (a_cnt_d == num_q);
        b_fin = !b_en_q || (b_cnt_d == num_q);
        if (a_fin && b_fin) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state_q    <= IDLE;
      num_q      <= '0;
      a_stride_q <= '0;
      b_en_q     <= 1'b0;
      b_base_q   <= '0;
      b_last_q   <= '0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      b_phase_q  <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      a_stride_q <= a_stride_d;
      b_en_q     <= b_en_d;
      b_base_q   <= b_base_d;
      b_last_q   <= b_last_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      b_phase_q  <= b_phase_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
    end
  end

  assign busy_o            = (state_q == RUN);
  assign done_o            = (state_q == DONE);
  assign im_a_data_valid_o = a_valid_q;
  assign im_b_data_valid_o = b_valid_q;
  assign lowdim_a_data_o   = {{(ImAddrWidth-AddrSelWidth){1'b0}}, a_addr_q};
  assign lowdim_b_data_o   = {{(ImAddrWidth-AddrSelWidth){1'b0}}, b_addr_q};

endmodule

// File: tb/tb_im_fetch_sequencer.sv
// tb/tb_im_fetch_sequencer.sv - scoreboard bench for im_fetch_sequencer
module tb_im_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_num = '0;
  logic [9:0]  cfg_a_base = '0;
  logic [9:0]  cfg_a_stride = '0;
  logic        cfg_b_en = 1'b0;
  logic [9:0]  cfg_b_base = '0;
  logic [15:0] cfg_b_period = '0;
  logic        busy, done;
  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic        a_ready = 1'b0;
  logic        b_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_exp = 0;
  int exp_a[$];
  int exp_b[$];
  bit          a_hold = 1'b0, b_hold = 1'b0;
  logic [31:0] a_prev = '0, b_prev = '0;

  im_fetch_sequencer dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .clr_i             (clr),
    .start_i           (start),
    .cfg_num_items_i   (cfg_num),
    .cfg_a_base_i      (cfg_a_base),
    .cfg_a_stride_i    (cfg_a_stride),
    .cfg_b_en_i        (cfg_b_en),
    .cfg_b_base_i      (cfg_b_base),
    .cfg_b_period_i    (cfg_b_period),
    .busy_o            (busy),
    .done_o            (done),
    .lowdim_a_data_o   (a_data),
    .im_a_data_valid_o (a_valid),
    .im_a_data_ready_i (a_ready),
    .lowdim_b_data_o   (b_data),
    .im_b_data_valid_o (b_valid),
    .im_b_data_ready_i (b_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake seen mid-cycle.
  always @(negedge clk) begin
    if (a_valid && a_ready) begin
      chk("a_hs_expected", longint'(exp_a.size() > 0), 1);
      if (exp_a.size() > 0) chk("a_addr", a_data, exp_a.pop_front());
    end
    if (b_valid && b_ready) begin
      chk("b_hs_expected", longint'(exp_b.size() > 0), 1);
      if (exp_b.size() > 0) chk("b_addr", b_data, exp_b.pop_front());
    end
    if (a_valid && a_hold) chk("a_addr_stable", a_data, a_prev);
    if (b_valid && b_hold) chk("b_addr_stable", b_data, b_prev);
    a_hold = a_valid && !a_ready;
    b_hold = b_valid && !b_ready;
    a_prev = a_data;
    b_prev = b_data;
    if (done) begin
      chk("done_expected", longint'(done_exp > 0), 1);
      chk("done_not_busy", busy, 0);
      if (done_exp > 0) done_exp--;
    end
  end

  task automatic run(input int num, input int a_base, input int a_stride,
                     input int b_en, input int b_base, input int b_period,
                     input bit b_toggle, input bit restart, input int exp_n);
    int n;
    cfg_num      = 16'(num);
    cfg_a_base   = 10'(a_base);
    cfg_a_stride = 10'(a_stride);
    cfg_b_en     = b_en[0];
    cfg_b_base   = 10'(b_base);
    cfg_b_period = 16'(b_period);
    a_ready = 1'b1;
    b_ready = 1'b1;
    done_exp++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble configuration: the sweep must use the latched copies.
    cfg_num      = 16'd3;
    cfg_a_base   = 10'd555;
    cfg_a_stride = 10'd77;
    cfg_b_en     = ~cfg_b_en;
    cfg_b_base   = 10'd333;
    cfg_b_period = 16'd9;
    n = 1;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (b_toggle) b_ready = ~b_ready;
      if (restart) start = (n == 2);
    end
    start = 1'b0;
    chk("run_cycles", n, exp_n);
    @(posedge clk); #1;
    chk("idle_after_done", {busy, done}, 0);
    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);
  endtask

  task automatic clear_test(input bit use_rst);
    cfg_num = 16'd8; cfg_a_base = 10'd10; cfg_a_stride = 10'd3;
    cfg_b_en = 1'b0; cfg_b_base = '0; cfg_b_period = '0;
    a_ready = 1'b1; b_ready = 1'b1;
    exp_a = '{10, 13};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_ready = 1'b0;
    if (use_rst) rst_ni = 1'b0;
    else         clr = 1'b1;
    @(posedge clk); #1;
    rst_ni = 1'b1; clr = 1'b0; a_ready = 1'b1;
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_a_valid", a_valid, 0);
    chk("clr_a_addr", a_data, 0);
    chk("clr_a_queue", exp_a.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    exp_a = '{10, 13, 16, 19, 22, 25, 28, 31};
    run(8, 10, 3, 0, 0, 0, 1'b0, 1'b0, 9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_addr", a_data, 0);
    chk("rst_b_addr", b_data, 0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    exp_a = '{10, 13, 16, 19};
    run(4, 10, 3, 0, 0, 0, 1'b0, 1'b1, 5);

    exp_a = '{1020, 1, 6};
    run(3, 1020, 5, 0, 0, 0, 1'b0, 1'b0, 4);

    exp_a = '{0, 1, 2, 3, 4};
    exp_b = '{100, 101, 100, 101, 100};
    run(5, 0, 1, 1, 100, 2, 1'b1, 1'b0, 10);

    exp_a = '{50, 50, 50};
    exp_b = '{7, 7, 7};
    run(3, 50, 0, 1, 7, 0, 1'b0, 1'b0, 4);

    run(0, 10, 3, 1, 5, 2, 1'b0, 1'b0, 1);

    clear_test(1'b0);
    clear_test(1'b1);

    chk("done_all_seen", done_exp, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
